// File: rtl/instr_fetch.sv
// Instruction fetch: issues one memory read at a time from the current PC
// and buffers returned words in a 2-entry FIFO toward decode.
module instr_fetch #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    FAULT
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              fault_q, fault_d;
  logic [1:0]        cnt_q, cnt_d;
  ent_t              e0_q, e0_d;
  ent_t              e1_q, e1_d;
  ent_t              new_ent;
  logic              push;
  logic              pop;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && cnt_q != 2'd2) begin
          addr_d  = pc_in;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          tmo_d   = '0;
          state_d = flush ? DROP : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          push    = !flush;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_d == CNT_W'(TIMEOUT_CYC)) begin
            state_d = FAULT;
          end else if (flush) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_d == CNT_W'(TIMEOUT_CYC)) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign req_d   = (state_d == REQ);
  assign fault_d = (state_d == FAULT);

  // Grant must advance the PC in the same cycle, so this stays combinational
  assign pc_en = (state_q == REQ) && mem_gnt && !flush;

  assign new_ent.pc   = addr_q;
  assign new_ent.data = mem_rdata;
  assign pop          = (cnt_q != 2'd0) && instr_ready;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      if (cnt_q == 2'd1) begin
        e0_d = new_ent;
      end else begin
        e0_d = e1_q;
        e1_d = new_ent;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        e0_d = new_ent;
      end else begin
        e1_d = new_ent;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign fault       = fault_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr_data  = e0_q.data;
  assign instr_pc    = e0_q.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC block, memory responder and an
// instruction-stream scoreboard drive directed and random traffic.
module tb_instr_fetch;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fault;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .pc_en(pc_en),
    .flush(flush),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .fault(fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_dat[$];
  int          pen_cyc[$];
  int          req_cyc[$];
  int          val_cyc[$];
  logic [31:0] pc_m;
  logic [31:0] out_addr;
  logic [31:0] fl_val;
  bit          pend, drop, fault_m, no_rsp;
  int          dly, w, cyc;
  int          p_gnt, p_ready, p_flush, min_dly, max_dly, fl_mode;

  task automatic clear_model();
    q.delete();
    pop_pc.delete();
    pop_dat.delete();
    pen_cyc.delete();
    req_cyc.delete();
    val_cyc.delete();
    pc_m    = 32'h0;
    pc_in   = 32'h0;
    pend    = 1'b0;
    drop    = 1'b0;
    fault_m = 1'b0;
    no_rsp  = 1'b0;
    dly     = 0;
    w       = 0;
    cyc     = 0;
    fl_mode = 0;
  endtask

  task automatic knobs(input int g, input int r, input int f,
                       input int dmin, input int dmax);
    p_gnt   = g;
    p_ready = r;
    p_flush = f;
    min_dly = dmin;
    max_dly = dmax;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: drive inputs after the edge, check, then advance the model
  task automatic step();
    bit          fl, do_pop;
    logic [31:0] ld;
    @(posedge clk);
    #1;
    mem_gnt    = mem_req && ($urandom_range(99) < p_gnt);
    mem_rvalid = pend && !no_rsp && (dly == 0);
    mem_rdata  = mem_rvalid ? 32'hA000_0000 + out_addr : $urandom;
    instr_ready = ($urandom_range(99) < p_ready);
    fl = ($urandom_range(999) < p_flush);
    ld = $urandom & 32'h0000_FFFC;
    if (fl_mode == 1 && mem_req) begin
      fl      = 1'b1;
      mem_gnt = 1'b1;
      ld      = fl_val;
      fl_mode = 0;
    end
    if (fl_mode == 2 && pend && !mem_rvalid) begin
      fl      = 1'b1;
      ld      = fl_val;
      fl_mode = 0;
    end
    flush = fl;
    #1;
    cyc++;
    chk("pc_en", pc_en, mem_req && mem_gnt && !flush);
    chk("valid", instr_valid, q.size() != 0);
    chk("fault", fault, fault_m);
    if (mem_req) begin
      chk("mem_addr", mem_addr, pc_m);
      chk("room", q.size() < 2, 1);
      req_cyc.push_back(cyc);
    end
    if (fault_m) chk("req_in_fault", mem_req, 0);
    if (instr_valid && q.size() != 0) begin
      chk("instr_pc", instr_pc, q[0].pc);
      chk("instr_data", instr_data, q[0].data);
      val_cyc.push_back(cyc);
    end
    if (pc_en) pen_cyc.push_back(cyc);
    do_pop = instr_valid && instr_ready && q.size() != 0;
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) begin
        pop_pc.push_back(q[0].pc);
        pop_dat.push_back(q[0].data);
        void'(q.pop_front());
      end
      if (mem_rvalid && !drop && !fault_m)
        q.push_back('{out_addr, mem_rdata});
    end
    if (mem_rvalid) begin
      pend = 1'b0;
      drop = 1'b0;
    end else if (pend) begin
      if (dly > 0) dly--;
      w++;
      if (w == TO) fault_m = 1'b1;
      if (flush) drop = 1'b1;
    end
    if (mem_req && mem_gnt) begin
      pend     = 1'b1;
      drop     = flush;
      out_addr = pc_m;
      dly      = $urandom_range(max_dly, min_dly);
      w        = 0;
    end
    if (flush) pc_m = ld;
    else if (pc_en) pc_m = pc_m + 32'd4;
    pc_in = pc_m;
  endtask

  task automatic wait_req(input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = mem_req;
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    pc_in = 32'h0;
    fl_val = 32'h0;

    // Full-speed streaming: one instruction every 3 cycles
    knobs(100, 100, 0, 0, 0);
    do_reset();
    repeat (10) step();
    if (pen_cyc.size() >= 3 && pop_pc.size() >= 3 &&
        req_cyc.size() >= 1 && val_cyc.size() >= 1) begin
      chk("gap1", pen_cyc[1] - pen_cyc[0], 3);
      chk("gap2", pen_cyc[2] - pen_cyc[1], 3);
      chk("lat", val_cyc[0] - req_cyc[0], 2);
      chk("seq_pc0", pop_pc[0], 32'h0);
      chk("seq_dat0", pop_dat[0], 32'hA000_0000);
      chk("seq_pc1", pop_pc[1], 32'h4);
      chk("seq_dat1", pop_dat[1], 32'hA000_0004);
      chk("seq_pc2", pop_pc[2], 32'h8);
      chk("seq_dat2", pop_dat[2], 32'hA000_0008);
    end else begin
      chk("stream_count", pop_pc.size(), 3);
    end

    // Back-pressure: FIFO fills to two and fetching stalls
    knobs(100, 0, 0, 0, 0);
    do_reset();
    repeat (12) step();
    chk("bp_pen", pen_cyc.size(), 2);
    chk("bp_req", mem_req, 0);
    chk("bp_head", instr_pc, 32'h0);
    p_ready = 100;
    repeat (2) step();
    chk("bp_pops", pop_pc.size(), 2);
    if (pop_pc.size() == 2) begin
      chk("bp_pop0", pop_pc[0], 32'h0);
      chk("bp_pop1", pop_pc[1], 32'h4);
    end
    wait_req("bp_resume");
    chk("bp_addr", mem_addr, 32'h8);
    chk("bp_empty", instr_valid, 0);

    // Flush while waiting on the response for 0x10
    knobs(100, 100, 0, 1, 1);
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = pend && out_addr == 32'h10;
    end
    if (!hit) chk("fw_timeout", 0, 1);
    fl_mode = 2;
    fl_val  = 32'h100;
    step();
    chk("fw_fired", fl_mode, 0);
    wait_req("fw_req");
    chk("fw_addr", mem_addr, 32'h100);
    chk("fw_empty", instr_valid, 0);

    // Flush coinciding with the grant
    fl_mode = 1;
    fl_val  = 32'h200;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = (fl_mode == 0);
    end
    if (!hit) chk("fg_timeout", 0, 1);
    chk("fg_pen", pc_en, 0);
    wait_req("fg_req");
    chk("fg_addr", mem_addr, 32'h200);
    chk("fg_empty", instr_valid, 0);

    // Response timeout leads to sticky fault, FIFO still drains
    knobs(100, 0, 0, 0, 0);
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = (q.size() == 1);
    end
    if (!hit) chk("to_fill", 0, 1);
    no_rsp = 1'b1;
    repeat (25) step();
    chk("to_fault", fault, 1);
    chk("to_req", mem_req, 0);
    p_ready = 100;
    repeat (3) step();
    chk("to_drained", instr_valid, 0);
    chk("to_pops", pop_pc.size(), 1);
    do_reset();

    // Asynchronous reset while a request is pending
    knobs(0, 100, 0, 0, 0);
    wait_req("ar_req");
    #1;
    reset = 1'b0;
    #1;
    chk("ar_pc_en", pc_en, 0);
    chk("ar_req0", mem_req, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_data", instr_data, 0);
    chk("ar_pc", instr_pc, 0);
    chk("ar_fault", fault, 0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("ar_ignored", instr_valid, 0);
    end
    mem_rvalid = 1'b0;
    clear_model();

    // Random traffic
    knobs(60, 60, 40, 0, 3);
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the program-counter interface: reads `pc_out` from the `pc` block and fetches the instruction word at that address from instruction memory.
- Pulses the `pc` block's enable on every accepted memory request.
- Buffers returned instructions in a 2-entry output FIFO (DEPTH=2) toward the decoder, using a valid/ready handshake.
- Sits between `pc`, instruction memory and the decode stage of the motor-controller core.

Parameters:
- ADDR_W, 32, address width; equals the `pc` width.
- DATA_W, 32, instruction word width.
- TIMEOUT_CYC, 15, maximum cycles waiting for `mem_rvalid` before faulting (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  ADDR_W  current PC (`pc_out` of the `pc` block).
- pc_en  output  1  one-cycle pulse that advances the PC; drives the `pc` block's `enable`.
- flush  input  1  redirect; asserted in the same cycle the `pc` block's `load` is asserted.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  request address; stable while `mem_req`=1.
- mem_gnt  input  1  memory accepted the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  DATA_W  read data.
- instr_valid  output  1  FIFO head valid.
- instr_data  output  DATA_W  FIFO head instruction.
- instr_pc  output  ADDR_W  address of the FIFO head instruction.
- instr_ready  input  1  decoder accepts the head.
- fault  output  1  sticky timeout flag.

Behaviour:
- Reset (`reset`=0, async):
  - State IDLE, FIFO empty (count=0), timeout counter 0.
  - All outputs 0: `pc_en`, `mem_req`, `mem_addr`, `instr_valid`, `instr_data`, `instr_pc`, `fault`.
  - Reset mid-transaction discards everything; a later `mem_rvalid` is ignored because the block is in IDLE.
- States:
  - IDLE:
    - If `flush`=0 and count<2: capture `pc_in` into `mem_addr`, go to REQ.
    - Otherwise stay.
  - REQ:
    - `mem_req`=1.
    - On `mem_gnt`=1 with `flush`=0: `pc_en`=1 for that cycle, clear the timeout counter, go to WAIT.
    - On `flush`=1 with `mem_gnt`=0: drop the request, go to IDLE.
    - On `flush`=1 with `mem_gnt`=1: `pc_en`=0, go to DROP.
  - WAIT:
    - On `mem_rvalid`: push {`mem_addr`, `mem_rdata`} into the FIFO, go to IDLE.
    - On `flush`: go to DROP.
    - Otherwise increment the counter; when counter==TIMEOUT_CYC go to FAULT.
  - DROP:
    - Wait for `mem_rvalid`, discard the data, go to IDLE.
    - The same timeout applies.
  - FAULT:
    - `fault`=1, `mem_req`=0, `pc_en`=0.
    - Terminal until reset.
    - The FIFO still drains to the decoder.
- Issue rule:
  - At most one outstanding request.
  - A new request is issued only when count<2; with the single-outstanding rule, a push can never overflow the FIFO.
- `pc_en`:
  - Exactly one pulse per granted, non-flushed request.
  - Never asserted outside REQ.
- `mem_addr` is registered: it changes only on the IDLE->REQ transition.
- Latency:
  - `pc_in` sampled in IDLE at cycle t -> `mem_req` high at t+1.
  - With immediate grant at t+1 and `mem_rvalid` at t+2, `instr_valid` rises at t+3 (FIFO output is registered).
  - Steady-state throughput: one instruction per 3 cycles.
- FIFO:
  - 2 entries.
  - Pop when `instr_valid` & `instr_ready`.
  - Push and pop in the same cycle is legal at any count; count is unchanged.
  - Pop with push while full: count stays 2.
- Flush:
  - Empties the FIFO on the next edge; `instr_valid`=0 the cycle after `flush`.
  - Has priority over push and pop in the same cycle; a response arriving in the flush cycle is discarded.
  - IDLE samples `pc_in` no earlier than the cycle after `flush`, so the loaded PC value is used.
- `instr_data` and `instr_pc` hold their values while `instr_valid`=1 and `instr_ready`=0.

Test Plan:
- Release reset with `pc_in`=0x0, `mem_gnt`=1, `mem_rvalid` one cycle after grant, `mem_rdata`=0xA0000000+addr, `instr_ready`=1, `pc` block incrementing by 4 -> `pc_en` pulses every 3 cycles; instr_pc/instr_data sequence 0x0/0xA0000000, 0x4/0xA0000004, 0x8/0xA0000008.
- Hold `instr_ready`=0 -> exactly 2 instructions (0x0, 0x4) buffered; `mem_req` stays 0 and `pc_en` does not pulse; raising `instr_ready` drains both in 2 cycles and fetching resumes at 0x8.
- Assert `flush` in WAIT while fetching 0x10, with `pc_in` loaded to 0x100 -> the response for 0x10 is discarded, the FIFO is emptied, and the next `mem_addr`=0x100.
- Assert `flush` in the same cycle as `mem_gnt` -> `pc_en` is not pulsed, the block enters DROP, and the response is swallowed.
- Hold `mem_rvalid`=0 for 15 cycles after grant -> `fault`=1 and `mem_req` stays 0; buffered instructions still drain; `reset` low clears `fault`.
- Drive `reset` low asynchronously while in REQ, then assert `mem_rvalid` -> all outputs 0 immediately; the response is ignored and `instr_valid` stays 0.
